// File: rtl/mem_ctrl.sv
// Byte-wide memory port sequencer: arbitrates instruction fetch against the load/store
// buffer, splits accesses into byte beats, extends load data and throttles I/O writes.
module mem_ctrl #(
   parameter logic [1:0] IO_PREFIX     = 2'b11,
   parameter bit         DATA_PRIORITY = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear,
   input  logic        io_buffer_full,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        need_data,
   input  logic        is_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_in,
   input  logic [2:0]  work_type,
   output logic        data_handle,
   output logic        data_ready,
   output logic [31:0] data_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_STORE = 2'd3;

   localparam int unsigned CNT_W = 3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [2:0]       wtype_q, wtype_d;
   logic [23:0]      buf_q, buf_d;
   logic             last_data_q, last_data_d;
   logic [31:0]      if_data_q, if_data_d;
   logic [31:0]      data_out_q, data_out_d;

   logic             is_read;
   logic             is_io;
   logic [CNT_W-1:0] n_bytes;
   logic             grant_data;
   logic             accept_ok;
   logic             fetch_acc;
   logic             read_done;
   logic             beat_ok;
   logic [31:0]      fetch_word;
   logic [31:0]      load_ext;
   logic [7:0]       store_byte;

   // Beat count and access classification come from the latched request.
   always_comb begin
      is_read = (state_q == S_FETCH) || (state_q == S_LOAD);
      is_io   = (addr_q[17:16] == IO_PREFIX);
      case (wtype_q[1:0])
         2'b00:   n_bytes = CNT_W'(1);
         2'b01:   n_bytes = CNT_W'(2);
         default: n_bytes = CNT_W'(4);
      endcase
   end

   // Tie-break: fixed data priority, or hand the grant to whoever lost last time.
   always_comb begin
      grant_data  = need_data && (!if_req || DATA_PRIORITY || !last_data_q);
      accept_ok   = !rst_in && (state_q == S_IDLE) && rdy_in && !rob_clear;
      data_handle = accept_ok && need_data && grant_data;
      fetch_acc   = accept_ok && if_req && !grant_data;
   end

   // Final read cycle merges the buffered bytes with the byte arriving now.
   always_comb begin
      read_done  = !rst_in && is_read && (cnt_q == n_bytes) && rdy_in && !rob_clear;
      fetch_word = {mem_din, buf_q};
      case (wtype_q)
         3'b000:  load_ext = {{24{mem_din[7]}}, mem_din};
         3'b001:  load_ext = {{16{mem_din[7]}}, mem_din, buf_q[7:0]};
         3'b100:  load_ext = {24'h000000, mem_din};
         3'b101:  load_ext = {16'h0000, mem_din, buf_q[7:0]};
         default: load_ext = {mem_din, buf_q};
      endcase
      if_done    = read_done && (state_q == S_FETCH);
      data_ready = read_done && (state_q == S_LOAD);
      if_data    = if_done ? fetch_word : if_data_q;
      data_out   = data_ready ? load_ext : data_out_q;
   end

   // Port drive: read address while beats remain, write beat only when it can issue.
   always_comb begin
      case (cnt_q[1:0])
         2'd0:    store_byte = wdata_q[7:0];
         2'd1:    store_byte = wdata_q[15:8];
         2'd2:    store_byte = wdata_q[23:16];
         default: store_byte = wdata_q[31:24];
      endcase
      beat_ok  = !rst_in && (state_q == S_STORE) && rdy_in && !(is_io && io_buffer_full);
      mem_wr   = beat_ok;
      mem_dout = beat_ok ? store_byte : 8'h00;
      if (!rst_in && is_read && (cnt_q < n_bytes)) begin
         mem_a = addr_q + 32'(cnt_q);
      end else if (beat_ok) begin
         mem_a = addr_q + 32'(cnt_q);
      end else begin
         mem_a = 32'h0000_0000;
      end
   end

   // Next-state logic; everything holds while rdy_in is low.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wtype_d     = wtype_q;
      buf_d       = buf_q;
      last_data_d = last_data_q;
      if_data_d   = if_data_q;
      data_out_d  = data_out_q;
      case (state_q)
         S_IDLE: begin
            if (data_handle) begin
               state_d     = is_write ? S_STORE : S_LOAD;
               cnt_d       = '0;
               addr_d      = data_addr;
               wdata_d     = data_in;
               wtype_d     = work_type;
               last_data_d = 1'b1;
            end else if (fetch_acc) begin
               state_d     = S_FETCH;
               cnt_d       = '0;
               addr_d      = if_addr;
               wtype_d     = 3'b010;
               last_data_d = 1'b0;
            end
         end
         S_FETCH, S_LOAD: begin
            if (rdy_in) begin
               if (rob_clear) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == n_bytes) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  if (state_q == S_FETCH) begin
                     if_data_d = fetch_word;
                  end else begin
                     data_out_d = load_ext;
                  end
               end else begin
                  case (cnt_q)
                     CNT_W'(1): buf_d[7:0]   = mem_din;
                     CNT_W'(2): buf_d[15:8]  = mem_din;
                     CNT_W'(3): buf_d[23:16] = mem_din;
                     default:   ;
                  endcase
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_STORE: begin
            if (beat_ok) begin
               if (cnt_q == n_bytes - CNT_W'(1)) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         wtype_q     <= 3'b000;
         buf_q       <= 24'h000000;
         last_data_q <= 1'b1;
         if_data_q   <= 32'h0000_0000;
         data_out_q  <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wtype_q     <= wtype_d;
         buf_q       <= buf_d;
         last_data_q <= last_data_d;
         if_data_q   <= if_data_d;
         data_out_q  <= data_out_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: one data-priority instance for most scenarios and an
// alternating-grant instance for the fairness scenario.
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, rob_clear, io_buffer_full;
   logic [7:0]  mem_din;
   logic        if_req, need_data, is_write;
   logic [31:0] if_addr, data_addr, data_in;
   logic [2:0]  work_type;

   logic [7:0]  mem_dout1, mem_dout0;
   logic [31:0] mem_a1, mem_a0, if_data1, if_data0, data_out1, data_out0;
   logic        mem_wr1, mem_wr0, if_done1, if_done0;
   logic        data_handle1, data_handle0, data_ready1, data_ready0;

   int errors = 0;
   int checks = 0;
   logic        sel0 = 1'b0;
   logic [31:0] rd_a;
   logic [7:0]  ram [logic [31:0]];

   always #5 clk_in = ~clk_in;

   mem_ctrl #(.IO_PREFIX(2'b11), .DATA_PRIORITY(1'b1)) dut1 (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout1),
      .mem_a(mem_a1), .mem_wr(mem_wr1), .if_req(if_req), .if_addr(if_addr),
      .if_done(if_done1), .if_data(if_data1), .need_data(need_data), .is_write(is_write),
      .data_addr(data_addr), .data_in(data_in), .work_type(work_type),
      .data_handle(data_handle1), .data_ready(data_ready1), .data_out(data_out1));

   mem_ctrl #(.IO_PREFIX(2'b11), .DATA_PRIORITY(1'b0)) dut0 (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout0),
      .mem_a(mem_a0), .mem_wr(mem_wr0), .if_req(if_req), .if_addr(if_addr),
      .if_done(if_done0), .if_data(if_data0), .need_data(need_data), .is_write(is_write),
      .data_addr(data_addr), .data_in(data_in), .work_type(work_type),
      .data_handle(data_handle0), .data_ready(data_ready0), .data_out(data_out0));

   // Synchronous-read RAM: data for an address appears the cycle after it is presented.
   assign rd_a = sel0 ? mem_a0 : mem_a1;
   always @(posedge clk_in) mem_din <= ram.exists(rd_a) ? ram[rd_a] : 8'h00;

   task automatic next_cycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b1; if_addr = 32'h400; need_data = 1'b1; is_write = 1'b0;
      data_addr = 32'h100; data_in = 32'h0; work_type = 3'b010;
      repeat (2) @(posedge clk_in);
      mid();
      checks++;
      if ({mem_a1, mem_dout1, mem_wr1, if_done1, data_ready1} !== 43'h0) begin
         errors++;
         $display("FAIL reset_port: got a=%h dout=%h wr=%b done=%b rdy=%b want all 0",
                  mem_a1, mem_dout1, mem_wr1, if_done1, data_ready1);
      end
      checks++;
      if ({if_data1, data_out1} !== 64'h0) begin
         errors++;
         $display("FAIL reset_data: got if_data=%h data_out=%h want 0", if_data1, data_out1);
      end
      checks++;
      if (data_handle1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_handle: got %b want 0", data_handle1);
      end
      next_cycle();
      rst_in = 1'b0; if_req = 1'b0; need_data = 1'b0;
      next_cycle();
   endtask

   task automatic test_load(input string name, input logic [31:0] addr, input logic [2:0] wt,
                            input int n, input logic [31:0] exp);
      data_addr = addr; work_type = wt; is_write = 1'b0; need_data = 1'b1;
      mid();
      checks++;
      if (data_handle1 !== 1'b1) begin
         errors++;
         $display("FAIL %s_handle: got %b want 1", name, data_handle1);
      end
      next_cycle();
      need_data = 1'b0;
      for (int k = 1; k <= n + 1; k++) begin
         mid();
         if (k <= n) begin
            checks++;
            if (mem_a1 !== addr + 32'(k - 1) || mem_wr1 !== 1'b0) begin
               errors++;
               $display("FAIL %s_addr%0d: got a=%h wr=%b want a=%h wr=0",
                        name, k, mem_a1, mem_wr1, addr + 32'(k - 1));
            end
         end
         checks++;
         if (data_ready1 !== 1'(k == n + 1)) begin
            errors++;
            $display("FAIL %s_ready%0d: got %b want %b", name, k, data_ready1, k == n + 1);
         end
         if (k == n + 1) begin
            checks++;
            if (data_out1 !== exp) begin
               errors++;
               $display("FAIL %s_data: got %h want %h", name, data_out1, exp);
            end
         end
         if (k <= n) next_cycle();
      end
      next_cycle();
   endtask

   task automatic test_store_sw();
      logic [31:0] d;
      d = 32'hDEAD_BEEF;
      data_addr = 32'h300; data_in = d; work_type = 3'b010; is_write = 1'b1; need_data = 1'b1;
      mid();
      checks++;
      if (data_handle1 !== 1'b1) begin
         errors++;
         $display("FAIL sw_handle: got %b want 1", data_handle1);
      end
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         need_data = 1'b0;
         rob_clear = (k == 2);
         mid();
         checks++;
         if (mem_wr1 !== 1'b1 || mem_a1 !== 32'h300 + 32'(k - 1) || mem_dout1 !== d[8*(k-1) +: 8]) begin
            errors++;
            $display("FAIL sw_beat%0d: got wr=%b a=%h dout=%h want wr=1 a=%h dout=%h",
                     k, mem_wr1, mem_a1, mem_dout1, 32'h300 + 32'(k - 1), d[8*(k-1) +: 8]);
         end
      end
      next_cycle();
      rob_clear = 1'b0;
      mid();
      checks++;
      if (mem_wr1 !== 1'b0 || mem_a1 !== 32'h0) begin
         errors++;
         $display("FAIL sw_after: got wr=%b a=%h want wr=0 a=0", mem_wr1, mem_a1);
      end
      next_cycle();
   endtask

   task automatic test_io_store();
      data_addr = 32'h0003_0000; data_in = 32'h41; work_type = 3'b000;
      is_write = 1'b1; need_data = 1'b1; io_buffer_full = 1'b1;
      mid();
      checks++;
      if (data_handle1 !== 1'b1) begin
         errors++;
         $display("FAIL io_handle: got %b want 1", data_handle1);
      end
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         need_data = 1'b0;
         mid();
         checks++;
         if (mem_wr1 !== 1'b0) begin
            errors++;
            $display("FAIL io_stall%0d: got wr=%b want 0", k, mem_wr1);
         end
      end
      next_cycle();
      io_buffer_full = 1'b0;
      mid();
      checks++;
      if (mem_wr1 !== 1'b1 || mem_dout1 !== 8'h41 || mem_a1 !== 32'h0003_0000) begin
         errors++;
         $display("FAIL io_beat: got wr=%b a=%h dout=%h want wr=1 a=00030000 dout=41",
                  mem_wr1, mem_a1, mem_dout1);
      end
      next_cycle();
      mid();
      checks++;
      if (mem_wr1 !== 1'b0) begin
         errors++;
         $display("FAIL io_after: got wr=%b want 0", mem_wr1);
      end
      next_cycle();
   endtask

   task automatic test_rdy_stall();
      rdy_in = 1'b0;
      data_addr = 32'h310; data_in = 32'h0000_A55A; work_type = 3'b001;
      is_write = 1'b1; need_data = 1'b1;
      mid();
      checks++;
      if (data_handle1 !== 1'b0) begin
         errors++;
         $display("FAIL rdy_nohandle: got %b want 0", data_handle1);
      end
      next_cycle();
      rdy_in = 1'b1;
      mid();
      checks++;
      if (data_handle1 !== 1'b1) begin
         errors++;
         $display("FAIL rdy_handle: got %b want 1", data_handle1);
      end
      next_cycle();
      need_data = 1'b0;
      mid();
      checks++;
      if (mem_wr1 !== 1'b1 || mem_a1 !== 32'h310 || mem_dout1 !== 8'h5A) begin
         errors++;
         $display("FAIL rdy_beat0: got wr=%b a=%h dout=%h want wr=1 a=310 dout=5a",
                  mem_wr1, mem_a1, mem_dout1);
      end
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         rdy_in = 1'b0;
         mid();
         checks++;
         if (mem_wr1 !== 1'b0) begin
            errors++;
            $display("FAIL rdy_frozen%0d: got wr=%b want 0", k, mem_wr1);
         end
      end
      next_cycle();
      rdy_in = 1'b1;
      mid();
      checks++;
      if (mem_wr1 !== 1'b1 || mem_a1 !== 32'h311 || mem_dout1 !== 8'hA5) begin
         errors++;
         $display("FAIL rdy_beat1: got wr=%b a=%h dout=%h want wr=1 a=311 dout=a5",
                  mem_wr1, mem_a1, mem_dout1);
      end
      next_cycle();
      mid();
      checks++;
      if (mem_wr1 !== 1'b0) begin
         errors++;
         $display("FAIL rdy_after: got wr=%b want 0", mem_wr1);
      end
      next_cycle();
   endtask

   task automatic test_priority();
      if_req = 1'b1; if_addr = 32'h400;
      need_data = 1'b1; is_write = 1'b0; data_addr = 32'h200; work_type = 3'b000;
      mid();
      checks++;
      if (data_handle1 !== 1'b1) begin
         errors++;
         $display("FAIL prio_handle: got %b want 1", data_handle1);
      end
      next_cycle();
      need_data = 1'b0;
      mid();
      checks++;
      if (mem_a1 !== 32'h200) begin
         errors++;
         $display("FAIL prio_load_addr: got %h want 00000200", mem_a1);
      end
      next_cycle();
      mid();
      checks++;
      if (data_ready1 !== 1'b1 || if_done1 !== 1'b0 || data_out1 !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL prio_load_done: got rdy=%b ifd=%b data=%h want rdy=1 ifd=0 data=ffffff80",
                  data_ready1, if_done1, data_out1);
      end
      next_cycle();
      mid();
      checks++;
      if (mem_a1 !== 32'h0 || data_handle1 !== 1'b0) begin
         errors++;
         $display("FAIL prio_idle: got a=%h handle=%b want a=0 handle=0", mem_a1, data_handle1);
      end
      for (int k = 4; k <= 8; k++) begin
         next_cycle();
         mid();
         if (k == 4) begin
            checks++;
            if (mem_a1 !== 32'h400) begin
               errors++;
               $display("FAIL prio_fetch_start: got a=%h want 00000400", mem_a1);
            end
         end
         checks++;
         if (if_done1 !== 1'(k == 8)) begin
            errors++;
            $display("FAIL prio_ifdone%0d: got %b want %b", k, if_done1, k == 8);
         end
         if (k == 8) begin
            checks++;
            if (if_data1 !== 32'h0010_0293) begin
               errors++;
               $display("FAIL prio_ifdata: got %h want 00100293", if_data1);
            end
         end
      end
      next_cycle();
      if_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_flush();
      if_req = 1'b1; if_addr = 32'h400;
      need_data = 1'b1; is_write = 1'b0; data_addr = 32'h100; work_type = 3'b010;
      mid();
      checks++;
      if (data_handle1 !== 1'b1) begin
         errors++;
         $display("FAIL flush_handle: got %b want 1", data_handle1);
      end
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         need_data = 1'b0;
         rob_clear = (k == 3);
         mid();
         checks++;
         if (data_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_noready%0d: got %b want 0", k, data_ready1);
         end
      end
      checks++;
      if (mem_a1 !== 32'h0) begin
         errors++;
         $display("FAIL flush_idle: got a=%h want 0", mem_a1);
      end
      for (int k = 5; k <= 9; k++) begin
         next_cycle();
         mid();
         if (k == 5) begin
            checks++;
            if (mem_a1 !== 32'h400) begin
               errors++;
               $display("FAIL flush_fetch_start: got a=%h want 00000400", mem_a1);
            end
         end
         checks++;
         if (if_done1 !== 1'(k == 9) || data_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_ifdone%0d: got ifd=%b rdy=%b want ifd=%b rdy=0",
                     k, if_done1, data_ready1, k == 9);
         end
      end
      checks++;
      if (if_data1 !== 32'h0010_0293) begin
         errors++;
         $display("FAIL flush_ifdata: got %h want 00100293", if_data1);
      end
      next_cycle();
      if_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_flush_last();
      need_data = 1'b1; is_write = 1'b0; data_addr = 32'h100; work_type = 3'b010;
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         need_data = 1'b0;
         rob_clear = (k == 5);
      end
      mid();
      checks++;
      if (data_ready1 !== 1'b0) begin
         errors++;
         $display("FAIL flushlast_ready: got %b want 0", data_ready1);
      end
      next_cycle();
      rob_clear = 1'b0;
      mid();
      checks++;
      if (data_ready1 !== 1'b0 || mem_a1 !== 32'h0) begin
         errors++;
         $display("FAIL flushlast_idle: got rdy=%b a=%h want rdy=0 a=0", data_ready1, mem_a1);
      end
      next_cycle();
   endtask

   task automatic test_alternate();
      logic [7:0] ev [4];
      int nev;
      logic drop, raise;
      nev = 0;
      rst_in = 1'b1;
      next_cycle();
      sel0 = 1'b1;
      if_req = 1'b1; if_addr = 32'h400;
      need_data = 1'b1; is_write = 1'b0; data_addr = 32'h200; work_type = 3'b000;
      rst_in = 1'b0;
      for (int c = 0; c < 80 && nev < 4; c++) begin
         mid();
         if (if_done0 === 1'b1) begin
            ev[nev] = "F";
            nev++;
         end
         if (data_ready0 === 1'b1 && nev < 4) begin
            ev[nev] = "D";
            nev++;
         end
         drop  = (data_handle0 === 1'b1);
         raise = (data_ready0 === 1'b1);
         next_cycle();
         if (drop) need_data = 1'b0;
         if (raise) need_data = 1'b1;
      end
      checks++;
      if (nev != 4) begin
         errors++;
         $display("FAIL alt_timeout: got %0d completions want 4", nev);
      end else begin
         checks++;
         if ({ev[0], ev[1], ev[2], ev[3]} !== "FDFD") begin
            errors++;
            $display("FAIL alt_order: got %s%s%s%s want FDFD", ev[0], ev[1], ev[2], ev[3]);
         end
      end
      if_req = 1'b0; need_data = 1'b0;
      next_cycle();
   endtask

   initial begin
      ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
      ram[32'h200] = 8'h80; ram[32'h201] = 8'h11; ram[32'h202] = 8'h80; ram[32'h203] = 8'hFF;
      ram[32'h400] = 8'h93; ram[32'h401] = 8'h02; ram[32'h402] = 8'h10; ram[32'h403] = 8'h00;
      test_reset();
      test_load("lw",  32'h100, 3'b010, 4, 32'h1234_5678);
      test_load("lb",  32'h200, 3'b000, 1, 32'hFFFF_FF80);
      test_load("lbu", 32'h200, 3'b100, 1, 32'h0000_0080);
      test_load("lh",  32'h202, 3'b001, 2, 32'hFFFF_FF80);
      test_load("lhu", 32'h202, 3'b101, 2, 32'h0000_FF80);
      test_store_sw();
      test_io_store();
      test_rdy_stall();
      test_priority();
      test_flush();
      test_flush_last();
      test_load("lw_again", 32'h100, 3'b010, 4, 32'h1234_5678);
      test_alternate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
